// File: rtl/des_perm_pipe_pkg.sv
// -----------------------------------------------------------------------------
// des_pkg
// Shared constants and types for the DES permutation pipeline:
//   - BLOCK_W        : DES block width (64 bits, DES bit n at vector index n)
//   - des_mode_e     : per-block mode encoding (IP, FP, pass, reserved)
//   - IP_TABLE       : initial permutation, entry n = source DES bit of output bit n
//   - FP_TABLE       : final permutation (inverse of IP), same indexing
//   - stage_t        : contents of one pipeline stage (valid, mode, data)
// -----------------------------------------------------------------------------
package des_pkg;

   localparam int BLOCK_W = 64;

   typedef enum logic [1:0] {
      MODE_IP   = 2'b00,
      MODE_FP   = 2'b01,
      MODE_PASS = 2'b10,
      MODE_RSVD = 2'b11
   } des_mode_e;

   // Output DES bit n is taken from input DES bit IP_TABLE[n].
   localparam logic [6:0] IP_TABLE [1:64] = '{
      7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18, 7'd10, 7'd2,
      7'd60, 7'd52, 7'd44, 7'd36, 7'd28, 7'd20, 7'd12, 7'd4,
      7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22, 7'd14, 7'd6,
      7'd64, 7'd56, 7'd48, 7'd40, 7'd32, 7'd24, 7'd16, 7'd8,
      7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,  7'd1,
      7'd59, 7'd51, 7'd43, 7'd35, 7'd27, 7'd19, 7'd11, 7'd3,
      7'd61, 7'd53, 7'd45, 7'd37, 7'd29, 7'd21, 7'd13, 7'd5,
      7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15, 7'd7
   };

   // Output DES bit n is taken from input DES bit FP_TABLE[n]; FP undoes IP.
   localparam logic [6:0] FP_TABLE [1:64] = '{
      7'd40, 7'd8,  7'd48, 7'd16, 7'd56, 7'd24, 7'd64, 7'd32,
      7'd39, 7'd7,  7'd47, 7'd15, 7'd55, 7'd23, 7'd63, 7'd31,
      7'd38, 7'd6,  7'd46, 7'd14, 7'd54, 7'd22, 7'd62, 7'd30,
      7'd37, 7'd5,  7'd45, 7'd13, 7'd53, 7'd21, 7'd61, 7'd29,
      7'd36, 7'd4,  7'd44, 7'd12, 7'd52, 7'd20, 7'd60, 7'd28,
      7'd35, 7'd3,  7'd43, 7'd11, 7'd51, 7'd19, 7'd59, 7'd27,
      7'd34, 7'd2,  7'd42, 7'd10, 7'd50, 7'd18, 7'd58, 7'd26,
      7'd33, 7'd1,  7'd41, 7'd9,  7'd49, 7'd17, 7'd57, 7'd25
   };

   typedef struct packed {
      logic               valid;
      logic [1:0]         mode;
      logic [BLOCK_W:1]   data;
   } stage_t;

endpackage : des_pkg

// File: rtl/des_perm_pipe_if.sv
// -----------------------------------------------------------------------------
// des_perm_pipe_if
// Handshake bundle of the DES permutation pipeline.
//   Input side : wInValid, rInReady, wMode, wInputData
//   Output side: rOutValid, wOutReady, rOutputData, rOutMode
//   Status     : rModeErr (sticky reserved-mode flag), rBlockCount
// Modports: master = block producer/consumer (bench or staging logic),
//           slave  = the permutation engine.
// -----------------------------------------------------------------------------
interface des_perm_pipe_if #(
   parameter int CNT_W = 16
);
   import des_pkg::*;

   logic                 wInValid;
   logic                 rInReady;
   logic [1:0]           wMode;
   logic [BLOCK_W:1]     wInputData;
   logic                 rOutValid;
   logic                 wOutReady;
   logic [BLOCK_W:1]     rOutputData;
   logic [1:0]           rOutMode;
   logic                 rModeErr;
   logic [CNT_W-1:0]     rBlockCount;

   modport master (
      output wInValid, wMode, wInputData, wOutReady,
      input  rInReady, rOutValid, rOutputData, rOutMode, rModeErr, rBlockCount
   );

   modport slave (
      input  wInValid, wMode, wInputData, wOutReady,
      output rInReady, rOutValid, rOutputData, rOutMode, rModeErr, rBlockCount
   );

endinterface : des_perm_pipe_if

// File: rtl/des_perm_pipe_lut.sv
// -----------------------------------------------------------------------------
// des_perm_lut
// Purely combinational DES bit permutation selected per block.
//   data_i [64:1] : input block, index n = DES bit n
//   mode_i [1:0]  : IP, FP, pass; reserved behaves as pass
//   data_o [64:1] : permuted block, index n = DES bit n
// -----------------------------------------------------------------------------
module des_perm_lut
   import des_pkg::*;
(
   input  logic [BLOCK_W:1] data_i,
   input  logic [1:0]       mode_i,
   output logic [BLOCK_W:1] data_o
);

   // Table-driven bit gather; every output bit picks one input bit.
   always_comb begin
      data_o = data_i;
      case (mode_i)
         MODE_IP: begin
            for (int n = 1; n <= BLOCK_W; n++) begin
               data_o[n] = data_i[IP_TABLE[n]];
            end
         end
         MODE_FP: begin
            for (int n = 1; n <= BLOCK_W; n++) begin
               data_o[n] = data_i[FP_TABLE[n]];
            end
         end
         MODE_PASS: data_o = data_i;
         MODE_RSVD: data_o = data_i;
         default:   data_o = data_i;
      endcase
   end

endmodule : des_perm_lut

// File: rtl/des_perm_pipe.sv
// -----------------------------------------------------------------------------
// des_perm_pipe
// Elastic, valid/ready DES permutation pipeline. The permutation is applied
// combinationally on the accepted block and captured in stage 0; later stages
// only move data forward. Bubbles collapse, so a stalled output lets upstream
// stages keep filling until every stage holds a block.
// Ports:
//   wClk    : clock, rising-edge
//   wReset  : synchronous active-high reset (discards in-flight blocks)
//   bus     : des_perm_pipe_if.slave (input/output handshakes, mode,
//             sticky rModeErr, rBlockCount of output handshakes)
// Parameters:
//   PIPE_STAGES : register stages input->output, legal 1..4 (= latency)
//   CNT_W       : width of rBlockCount
// -----------------------------------------------------------------------------
module des_perm_pipe
   import des_pkg::*;
#(
   parameter int PIPE_STAGES = 2,
   parameter int CNT_W       = 16
)(
   input  logic           wClk,
   input  logic           wReset,
   des_perm_pipe_if.slave bus
);

   localparam int LAST = PIPE_STAGES - 1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   stage_t                 stage_q [PIPE_STAGES];
   stage_t                 stage_d [PIPE_STAGES];
   logic [PIPE_STAGES-1:0] adv_s;
   logic [BLOCK_W:1]       perm_s;
   logic                   in_ready_s;
   logic                   accept_s;
   logic                   emit_s;
   logic                   mode_err_q;
   logic                   mode_err_d;
   logic [CNT_W-1:0]       cnt_q;
   logic [CNT_W-1:0]       cnt_d;

   des_perm_lut u_lut (
      .data_i (bus.wInputData),
      .mode_i (bus.wMode),
      .data_o (perm_s)
   );

   // Advance chain from the output back: a stage moves when it is empty or
   // its successor moves; this is what lets bubbles collapse.
   always_comb begin
      adv_s       = '0;
      adv_s[LAST] = !stage_q[LAST].valid || bus.wOutReady;
      for (int k = LAST - 1; k >= 0; k--) begin
         adv_s[k] = !stage_q[k].valid || adv_s[k+1];
      end
   end

   // Handshake qualifiers; ready depends on wOutReady but never on wInValid.
   always_comb begin
      in_ready_s = !wReset && adv_s[0];
      accept_s   = bus.wInValid && in_ready_s;
      emit_s     = stage_q[LAST].valid && bus.wOutReady;
   end

   // Next-state for the stage registers, the sticky error and the counter.
   always_comb begin
      for (int k = 0; k < PIPE_STAGES; k++) begin
         stage_d[k] = stage_q[k];
      end
      if (adv_s[0]) begin
         stage_d[0].valid = accept_s;
         stage_d[0].mode  = bus.wMode;
         stage_d[0].data  = perm_s;
      end else begin
         stage_d[0] = stage_q[0];
      end
      for (int k = 1; k < PIPE_STAGES; k++) begin
         if (adv_s[k]) begin
            stage_d[k] = stage_q[k-1];
         end else begin
            stage_d[k] = stage_q[k];
         end
      end
      if (accept_s && (bus.wMode == MODE_RSVD)) begin
         mode_err_d = 1'b1;
      end else begin
         mode_err_d = mode_err_q;
      end
      if (emit_s) begin
         cnt_d = cnt_q + CNT_ONE;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // State registers with synchronous reset; reset drops in-flight blocks.
   always_ff @(posedge wClk) begin
      if (wReset) begin
         for (int k = 0; k < PIPE_STAGES; k++) begin
            stage_q[k] <= '0;
         end
         mode_err_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         for (int k = 0; k < PIPE_STAGES; k++) begin
            stage_q[k] <= stage_d[k];
         end
         mode_err_q <= mode_err_d;
         cnt_q      <= cnt_d;
      end
   end

   assign bus.rInReady    = in_ready_s;
   assign bus.rOutValid   = stage_q[LAST].valid;
   assign bus.rOutputData = stage_q[LAST].data;
   assign bus.rOutMode    = stage_q[LAST].mode;
   assign bus.rModeErr    = mode_err_q;
   assign bus.rBlockCount = cnt_q;

endmodule : des_perm_pipe

// File: tb/tb_des_perm_pipe.sv
// -----------------------------------------------------------------------------
// tb_des_perm_pipe
// Directed bench for des_perm_pipe: known-answer IP/FP vectors, FP(IP(x))
// identity, stall/drain, random handshakes against a scoreboard, reserved mode
// and mid-stream reset. The reference IP is built from its row/column formula
// and FP as its inverse, independently of the RTL tables.
// -----------------------------------------------------------------------------
module tb_des_perm_pipe;

   localparam int PIPE_STAGES = 2;
   localparam int CNT_W       = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   des_perm_pipe_if #(.CNT_W(CNT_W)) bus ();

   des_perm_pipe #(.PIPE_STAGES(PIPE_STAGES), .CNT_W(CNT_W)) dut (
      .wClk   (clk),
      .wReset (rst),
      .bus    (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int emitted  = 0;

   logic [64:1] sb_data [$];
   logic [1:0]  sb_mode [$];
   logic [64:1] cap     [$];

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   // Hex string with DES bit 1 leftmost -> vector with DES bit n at index n.
   function automatic logic [64:1] hex2des(input logic [63:0] h);
      logic [64:1] v;
      for (int n = 1; n <= 64; n++) v[n] = h[64-n];
      return v;
   endfunction

   function automatic int ip_src(input int i);
      int r, c;
      r = (i - 1) / 8;
      c = (i - 1) % 8;
      if (r < 4) return 58 + 2 * r - 8 * c;
      else return 57 + 2 * (r - 4) - 8 * c;
   endfunction

   function automatic logic [64:1] m_ip(input logic [64:1] x);
      logic [64:1] y;
      for (int i = 1; i <= 64; i++) y[i] = x[ip_src(i)];
      return y;
   endfunction

   function automatic logic [64:1] m_fp(input logic [64:1] x);
      logic [64:1] y;
      for (int i = 1; i <= 64; i++) y[ip_src(i)] = x[i];
      return y;
   endfunction

   function automatic logic [64:1] model(input logic [64:1] d, input logic [1:0] md);
      case (md)
         2'b00:   return m_ip(d);
         2'b01:   return m_fp(d);
         default: return d;
      endcase
   endfunction

   // One cycle: drive at negedge, observe handshakes just after, score outputs.
   task automatic cycle(input logic iv, input logic [1:0] md, input logic [64:1] d,
                        input logic ordy, output logic acc);
      logic [64:1] exp_d;
      logic [1:0]  exp_m;
      @(negedge clk);
      bus.wInValid   = iv;
      bus.wMode      = md;
      bus.wInputData = d;
      bus.wOutReady  = ordy;
      #1;
      acc = iv && bus.rInReady;
      if (bus.rOutValid && ordy) begin
         check_eq("sb_nonempty", 64'(sb_data.size() != 0), 64'd1);
         if (sb_data.size() != 0) begin
            exp_d = sb_data.pop_front();
            exp_m = sb_mode.pop_front();
            check_eq("out_data", bus.rOutputData, exp_d);
            check_eq("out_mode", 64'(bus.rOutMode), 64'(exp_m));
         end
         cap.push_back(bus.rOutputData);
         emitted++;
      end
      if (acc) begin
         sb_data.push_back(model(d, md));
         sb_mode.push_back(md);
      end
   endtask

   task automatic drain(input string tag);
      logic acc;
      for (int i = 0; i < 40 && sb_data.size() != 0; i++) cycle(1'b0, 2'b10, '0, 1'b1, acc);
      check_eq({tag, "_drained"}, 64'(sb_data.size()), 64'd0);
      cycle(1'b0, 2'b10, '0, 1'b1, acc);
      check_eq({tag, "_count"}, 64'(bus.rBlockCount), 64'(16'(emitted)));
   endtask

   // Single block with ready high: checks latency, data, mode and count.
   task automatic kat(input string tag, input logic [1:0] md, input logic [64:1] d,
                      input logic [64:1] exp);
      @(negedge clk);
      bus.wInValid   = 1'b1;
      bus.wMode      = md;
      bus.wInputData = d;
      bus.wOutReady  = 1'b1;
      #1;
      check_eq({tag, "_in_ready"}, 64'(bus.rInReady), 64'd1);
      for (int i = 1; i <= PIPE_STAGES; i++) begin
         @(negedge clk);
         bus.wInValid = 1'b0;
         #1;
         check_eq({tag, "_valid_lat"}, 64'(bus.rOutValid), 64'(i == PIPE_STAGES));
      end
      check_eq({tag, "_data"}, bus.rOutputData, exp);
      check_eq({tag, "_mode"}, 64'(bus.rOutMode), 64'(md));
      emitted++;
      @(negedge clk);
      #1;
      check_eq({tag, "_valid_after"}, 64'(bus.rOutValid), 64'd0);
      check_eq({tag, "_count"}, 64'(bus.rBlockCount), 64'(16'(emitted)));
   endtask

   logic [64:1] orig [1000];
   logic [64:1] mid  [$];
   logic [64:1] blk  [6];
   logic [64:1] held;
   logic        acc;
   int          idx, stalls, guard;

   initial begin
      rst            = 1'b1;
      bus.wInValid   = 1'b0;
      bus.wMode      = 2'b00;
      bus.wInputData = '0;
      bus.wOutReady  = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      #1;
      check_eq("rst_in_ready", 64'(bus.rInReady), 64'd0);
      check_eq("rst_out_valid", 64'(bus.rOutValid), 64'd0);
      check_eq("rst_count", 64'(bus.rBlockCount), 64'd0);
      check_eq("rst_mode_err", 64'(bus.rModeErr), 64'd0);
      check_eq("rst_data", bus.rOutputData, 64'd0);
      rst = 1'b0;
      #1;
      check_eq("rel_in_ready", 64'(bus.rInReady), 64'd1);

      // Known answers
      kat("kat_ip", 2'b00, hex2des(64'h0123456789ABCDEF), hex2des(64'hCC00CCFFF0AAF0AA));
      kat("kat_fp", 2'b01, hex2des(64'hCC00CCFFF0AAF0AA), hex2des(64'h0123456789ABCDEF));

      // Back-to-back IP then FP of 1000 random blocks
      for (int i = 0; i < 1000; i++) orig[i] = {$urandom, $urandom};
      cap.delete();
      idx = 0; stalls = 0; guard = 0;
      while (idx < 1000 && guard < 1100) begin
         cycle(1'b1, 2'b00, orig[idx], 1'b1, acc);
         if (acc) idx++;
         else stalls++;
         guard++;
      end
      drain("ip_stream");
      check_eq("ip_stream_stalls", 64'(stalls), 64'd0);
      check_eq("ip_stream_outs", 64'(cap.size()), 64'd1000);
      mid = cap;
      cap.delete();
      idx = 0; stalls = 0; guard = 0;
      while (idx < mid.size() && guard < 1100) begin
         cycle(1'b1, 2'b01, mid[idx], 1'b1, acc);
         if (acc) idx++;
         else stalls++;
         guard++;
      end
      drain("fp_stream");
      check_eq("fp_stream_stalls", 64'(stalls), 64'd0);
      check_eq("fp_stream_outs", 64'(cap.size()), 64'd1000);
      for (int i = 0; i < 1000 && i < cap.size(); i++) check_eq("fpip_identity", cap[i], orig[i]);

      // Stall with continuous input, then in-order drain
      for (int i = 0; i < 6; i++) blk[i] = {$urandom, $urandom};
      cap.delete();
      idx = 0;
      for (int c = 0; c < 5; c++) begin
         cycle(1'b1, 2'(idx % 2), blk[idx], 1'b0, acc);
         if (acc) idx++;
         if (c == 2) held = bus.rOutputData;
      end
      check_eq("stall_buffered", 64'(idx), 64'(PIPE_STAGES));
      check_eq("stall_in_ready", 64'(bus.rInReady), 64'd0);
      check_eq("stall_out_valid", 64'(bus.rOutValid), 64'd1);
      check_eq("stall_data_held", bus.rOutputData, held);
      check_eq("stall_mode_held", 64'(bus.rOutMode), 64'd0);
      guard = 0;
      while (idx < 6 && guard < 50) begin
         cycle(1'b1, 2'(idx % 2), blk[idx], 1'b1, acc);
         if (acc) idx++;
         guard++;
      end
      drain("stall");
      check_eq("stall_outs", 64'(cap.size()), 64'd6);

      // Random valid/ready
      for (int c = 0; c < 10000; c++) begin
         cycle(1'($urandom % 2), 2'($urandom_range(0, 2)), {$urandom, $urandom},
               1'($urandom % 2), acc);
      end
      drain("random");
      check_eq("random_mode_err", 64'(bus.rModeErr), 64'd0);

      // Reserved mode: pass-through, reported as 11, sticky error
      kat("rsvd", 2'b11, hex2des(64'h0F0F0F0F0F0F0F0F), hex2des(64'h0F0F0F0F0F0F0F0F));
      check_eq("rsvd_mode_err", 64'(bus.rModeErr), 64'd1);
      kat("after_rsvd", 2'b10, hex2des(64'h1122334455667788), hex2des(64'h1122334455667788));
      check_eq("rsvd_err_sticky", 64'(bus.rModeErr), 64'd1);

      // Reset with two blocks in flight and output stalled
      cycle(1'b1, 2'b00, {$urandom, $urandom}, 1'b0, acc);
      cycle(1'b1, 2'b01, {$urandom, $urandom}, 1'b0, acc);
      @(negedge clk);
      rst          = 1'b1;
      bus.wInValid = 1'b0;
      #1;
      check_eq("mrst_in_ready", 64'(bus.rInReady), 64'd0);
      @(negedge clk);
      #1;
      check_eq("mrst_out_valid", 64'(bus.rOutValid), 64'd0);
      check_eq("mrst_count", 64'(bus.rBlockCount), 64'd0);
      check_eq("mrst_mode_err", 64'(bus.rModeErr), 64'd0);
      sb_data.delete();
      sb_mode.delete();
      emitted = 0;
      rst = 1'b0;
      #1;
      check_eq("mrst_rel_ready", 64'(bus.rInReady), 64'd1);
      for (int c = 0; c < 4; c++) begin
         cycle(1'b0, 2'b10, '0, 1'b1, acc);
         check_eq("mrst_no_stale", 64'(bus.rOutValid), 64'd0);
      end
      kat("post_rst", 2'b00, hex2des(64'h0123456789ABCDEF), hex2des(64'hCC00CCFFF0AAF0AA));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_des_perm_pipe
